icb_buffer: RTL and testbench
=============================

// Module: icb_buffer
// PURPOSE
//   Parametrised ICB pipeline buffer between an upstream ICB master (s_icb_*) and a
//   downstream ICB slave (m_icb_*), e.g. in front of the ICB-to-APB bridge.
//   - Cuts all combinational paths: independent command and response FIFOs.
//   - Enforces a cap on outstanding transactions.
//   - Reports occupancy and idle status.
// PARAMETERS
//   AW        32  address width
//   DW        64  data width; must be a multiple of 8; wmask width is DW/8
//   CMD_DEPTH  2  command FIFO entries; power of 2, >=2
//   RSP_DEPTH  2  response FIFO entries; power of 2, >=2
//   MAX_OUT    4  max outstanding transactions, 1..255; CW = $clog2(MAX_OUT+1)
// PORTS
//   clk              in   1     single clock, all logic on posedge
//   rst_n            in   1     asynchronous reset, active-low
//   s_icb_cmd_valid  in   1     upstream command valid
//   s_icb_cmd_ready  out  1     upstream command ready
//   s_icb_cmd_addr   in   AW    command address
//   s_icb_cmd_read   in   1     1 = read, 0 = write
//   s_icb_cmd_wdata  in   DW    write data
//   s_icb_cmd_wmask  in   DW/8  byte write mask
//   s_icb_rsp_valid  out  1     upstream response valid
//   s_icb_rsp_ready  in   1     upstream response ready
//   s_icb_rsp_rdata  out  DW    read data
//   s_icb_rsp_err    out  1     response error
//   m_icb_cmd_*      out/in     downstream mirror of s_icb_cmd_* (valid/addr/read/wdata/wmask out, ready in)
//   m_icb_rsp_*      in/out     downstream mirror of s_icb_rsp_* (valid/rdata/err in, ready out)
//   outstanding      out  CW    count of accepted commands not yet answered upstream
//   idle             out  1     1 when outstanding==0 and both FIFOs empty
// BEHAVIOUR
//   Handshake: a transfer occurs on any channel when valid && ready at posedge clk.
//     - Once asserted, valid and payload hold until the handshake.
//     - Responses return in command order; no IDs, no reordering.
//   Reset (rst_n low, async):
//     - FIFO pointers, FIFO counts and outstanding = 0.
//     - s_icb_rsp_valid = 0, m_icb_cmd_valid = 0.
//     - Ready outputs forced to 0 while rst_n is low.
//     - idle = 1; data outputs = 0.
//     - A reset mid-transaction discards all buffered commands and responses.
//   Command path:
//     - s_icb_cmd_ready = rst_n && !cmd_full && (outstanding < MAX_OUT).
//     - Ready is registered-state only and never depends on m_icb_cmd_ready.
//     - On upstream handshake the entry {addr,read,wdata,wmask} is pushed.
//     - m_icb_cmd_valid = !cmd_empty, with FIFO head driven on m_icb_cmd_*.
//     - Latency: upstream accept at edge N -> m_icb_cmd_valid high from N+1.
//   Response path:
//     - m_icb_rsp_ready = rst_n && !rsp_full.
//     - s_icb_rsp_valid = !rsp_empty, with head {rdata,err} driven.
//     - Latency: downstream rsp accept at edge N -> s_icb_rsp_valid high from N+1.
//     - Minimum added round trip: 2 cycles.
//   FIFOs:
//     - Circular, pointer width $clog2(DEPTH)+1; MSB distinguishes full from empty.
//     - Pointers wrap DEPTH-1 -> 0.
//     - Push when full is impossible (ready=0), even if a pop happens the same cycle.
//     - Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
//     - Push into an empty FIFO: visible next cycle only; no fall-through.
//   Outstanding counter:
//     - +1 on an upstream cmd handshake; -1 on an upstream rsp handshake.
//     - Both in the same cycle: unchanged.
//     - Saturation is impossible by construction. An assertion flags underflow
//       (rsp handshake at 0) and overflow.
//     - At outstanding==MAX_OUT, cmd_ready=0 even if an rsp handshake occurs that
//       cycle; ready reopens next cycle.
//   Error handling: err passes through unmodified; the buffer generates no errors itself.
// TESTING
//   T1 reset: hold rst_n=0 with s_icb_cmd_valid=1 -> both readies 0, both valids 0,
//      idle=1; release -> s_icb_cmd_ready=1 on next posedge.
//   T2 single read addr=0x1000: slave returns rdata=0xDEADBEEF_CAFEF00D, err=0 one cycle
//      after m cmd handshake -> master sees matching rsp exactly 2 cycles later than
//      direct connection; outstanding goes 0->1->0.
//   T3 outstanding cap MAX_OUT=4: slave holds rsp back, master issues 6 writes -> exactly
//      4 accepted, s_icb_cmd_ready=0 at outstanding==4; after one rsp handshake the 5th is
//      accepted the cycle after.
//   T4 backpressure / full: m_icb_cmd_ready=0, CMD_DEPTH=2 -> 2 cmds accepted then ready=0;
//      release -> cmds leave in order, addr 0x0,0x8; no loss or duplicate.
//   T5 wrap-around and stream: 64 back-to-back mixed rd/wr with random ready on both sides,
//      wmask=0xFF/0x0F -> scoreboard: in-order, payload bit-exact, err=1 on addr 0xBAD0 propagated.
//   T6 reset mid-operation: assert rst_n with 2 cmds and 1 rsp buffered -> all valids drop
//      immediately, outstanding=0, idle=1; a fresh read after release completes normally.

Source files
------------

// File: rtl/icb_buffer_if.sv
// ICB bus bundle: one command channel (master -> slave) and one response
// channel (slave -> master), each with a valid/ready handshake.
interface icb_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 64
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic            cmd_read;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wmask;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/icb_buffer.sv
// ICB pipeline buffer: registered command and response FIFOs between an
// upstream master and a downstream slave, with a cap on outstanding
// transactions. Every ready/valid toward either side comes from flops only,
// so no combinational path crosses the buffer.

// Circular FIFO with one extra pointer bit telling full from empty.
// The head is read straight from storage, so a push into an empty FIFO
// becomes visible only on the following cycle.
module icb_buffer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Status flags and head entry, derived from the pointers only.
    always_comb begin
        empty     = (wptr_q == rptr_q);
        full      = (wptr_q[IW] != rptr_q[IW]) && (wptr_q[IW-1:0] == rptr_q[IW-1:0]);
        head_data = mem_q[rptr_q[IW-1:0]];
    end

    // Next pointers and storage; a push while full is dropped even if a pop happens too.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push && !full) begin
            mem_d[wptr_q[IW-1:0]] = push_data;
            wptr_d                = wptr_q + PW'(1);
        end
        if (pop && !empty) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    // Pointer and storage registers; reset clears everything so outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end
endmodule

module icb_buffer #(
    parameter  int AW        = 32,
    parameter  int DW        = 64,
    parameter  int CMD_DEPTH = 2,
    parameter  int RSP_DEPTH = 2,
    parameter  int MAX_OUT   = 4,
    localparam int CW        = $clog2(MAX_OUT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    icb_buffer_if.slave         s_icb,
    icb_buffer_if.master        m_icb,
    output logic [CW-1:0]       outstanding,
    output logic                idle
);
    localparam int MW    = DW / 8;
    localparam int CMD_W = AW + 1 + DW + MW;
    localparam int RSP_W = DW + 1;

    logic             cmd_push, cmd_pop, cmd_empty, cmd_full;
    logic [CMD_W-1:0] cmd_head;
    logic             rsp_push, rsp_pop, rsp_empty, rsp_full;
    logic [RSP_W-1:0] rsp_head;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic             at_cap;

    // Upstream command acceptance: only registered state and rst_n decide ready.
    assign at_cap          = (outstanding_q >= CW'(MAX_OUT));
    assign s_icb.cmd_ready = rst_n && !cmd_full && !at_cap;
    assign cmd_push        = s_icb.cmd_valid && s_icb.cmd_ready;

    // Downstream command presentation from the FIFO head.
    assign m_icb.cmd_valid = !cmd_empty;
    assign cmd_pop         = m_icb.cmd_valid && m_icb.cmd_ready;
    assign {m_icb.cmd_addr, m_icb.cmd_read, m_icb.cmd_wdata, m_icb.cmd_wmask} = cmd_head;

    // Downstream response acceptance and upstream response presentation.
    assign m_icb.rsp_ready = rst_n && !rsp_full;
    assign rsp_push        = m_icb.rsp_valid && m_icb.rsp_ready;
    assign s_icb.rsp_valid = !rsp_empty;
    assign rsp_pop         = s_icb.rsp_valid && s_icb.rsp_ready;
    assign {s_icb.rsp_rdata, s_icb.rsp_err} = rsp_head;

    assign outstanding = outstanding_q;
    assign idle        = (outstanding_q == '0) && cmd_empty && rsp_empty;

    icb_buffer_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_push),
        .push_data ({s_icb.cmd_addr, s_icb.cmd_read, s_icb.cmd_wdata, s_icb.cmd_wmask}),
        .pop       (cmd_pop),
        .head_data (cmd_head),
        .empty     (cmd_empty),
        .full      (cmd_full)
    );

    icb_buffer_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_push),
        .push_data ({m_icb.rsp_rdata, m_icb.rsp_err}),
        .pop       (rsp_pop),
        .head_data (rsp_head),
        .empty     (rsp_empty),
        .full      (rsp_full)
    );

    // Outstanding count: up on upstream command accept, down on upstream response delivery.
    always_comb begin
        outstanding_d = outstanding_q;
        if (cmd_push && !rsp_pop) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (rsp_pop && !cmd_push) begin
            outstanding_d = outstanding_q - CW'(1);
        end
    end

    // Outstanding count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    // A response with nothing outstanding, or an accept beyond the cap, means broken bookkeeping.
    assert property (@(posedge clk) disable iff (!rst_n) !(rsp_pop && (outstanding_q == '0)));
    assert property (@(posedge clk) disable iff (!rst_n) !(cmd_push && !rsp_pop && at_cap));
endmodule

// File: tb/tb_icb_buffer.sv
// Testbench for icb_buffer: a cycle-stepped master, a downstream slave model
// and a queue-based reference of what each side should see and when.
module tb_icb_buffer;
    localparam int AW        = 32;
    localparam int DW        = 64;
    localparam int CMD_DEPTH = 2;
    localparam int RSP_DEPTH = 2;
    localparam int MAX_OUT   = 4;
    localparam int CW        = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic            read;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] wmask;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [CW-1:0] outstanding;
    logic          idle;

    icb_buffer_if #(.AW(AW), .DW(DW)) s_if ();
    icb_buffer_if #(.AW(AW), .DW(DW)) m_if ();

    icb_buffer #(
        .AW(AW), .DW(DW), .CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_icb       (s_if),
        .m_icb       (m_if),
        .outstanding (outstanding),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;
    int n_accepted = 0;
    int n_rsp      = 0;
    int err_seen   = 0;
    int last_cmd_cycle = 0;
    int last_rsp_cycle = 0;

    int cmd_valid_pct  = 100;
    int mcmd_ready_pct = 100;
    int slave_rsp_pct  = 100;
    int srsp_ready_pct = 100;

    // Reference state: commands still to issue, commands inside the cmd FIFO,
    // commands accepted but not yet answered upstream, commands held by the slave.
    cmd_t tx_q[$];
    cmd_t exp_down[$];
    cmd_t exp_up[$];
    cmd_t slave_q[$];
    int   rsp_buf_cnt = 0;
    bit   m_hold  = 1'b0;
    bit   sl_hold = 1'b0;

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    endtask

    function automatic bit chance(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    // What the downstream slave answers for a given command: {rdata, err}.
    function automatic logic [DW:0] slave_reply(input cmd_t c);
        logic [DW-1:0] rdata;
        if (!c.read)                rdata = '0;
        else if (c.addr == 32'h1000) rdata = 64'hDEADBEEF_CAFEF00D;
        else                        rdata = {~c.addr, c.addr};
        return {rdata, (c.addr == 32'hBAD0)};
    endfunction

    function automatic cmd_t make_cmd(input logic [AW-1:0] addr, input logic read);
        cmd_t c;
        c.addr  = addr;
        c.read  = read;
        c.wdata = {$urandom, $urandom};
        c.wmask = ($urandom_range(1) == 1) ? 8'hFF : 8'h0F;
        return c;
    endfunction

    // One clock cycle: drive both sides, check the buffer against the model, commit handshakes.
    task automatic applyStimulus();
        bit   s_cmd_hs, m_cmd_hs, m_rsp_hs, s_rsp_hs;
        cmd_t down_c;
        @(negedge clk);
        if (!m_hold && tx_q.size() > 0 && chance(cmd_valid_pct)) m_hold = 1'b1;
        s_if.cmd_valid = m_hold;
        if (m_hold) begin
            s_if.cmd_addr  = tx_q[0].addr;
            s_if.cmd_read  = tx_q[0].read;
            s_if.cmd_wdata = tx_q[0].wdata;
            s_if.cmd_wmask = tx_q[0].wmask;
        end
        m_if.cmd_ready = chance(mcmd_ready_pct);
        if (!sl_hold && slave_q.size() > 0 && chance(slave_rsp_pct)) sl_hold = 1'b1;
        m_if.rsp_valid = sl_hold;
        if (sl_hold) {m_if.rsp_rdata, m_if.rsp_err} = slave_reply(slave_q[0]);
        else         {m_if.rsp_rdata, m_if.rsp_err} = '0;
        s_if.rsp_ready = chance(srsp_ready_pct);
        #1;
        checkOutput("s_cmd_ready", s_if.cmd_ready, (exp_down.size() < CMD_DEPTH) && (exp_up.size() < MAX_OUT));
        checkOutput("m_cmd_valid", m_if.cmd_valid, exp_down.size() > 0);
        checkOutput("m_rsp_ready", m_if.rsp_ready, rsp_buf_cnt < RSP_DEPTH);
        checkOutput("s_rsp_valid", s_if.rsp_valid, rsp_buf_cnt > 0);
        checkOutput("outstanding", outstanding, exp_up.size());
        checkOutput("idle", idle, exp_up.size() == 0);
        s_cmd_hs = s_if.cmd_valid && s_if.cmd_ready;
        m_cmd_hs = m_if.cmd_valid && m_if.cmd_ready && (exp_down.size() > 0);
        m_rsp_hs = m_if.rsp_valid && m_if.rsp_ready;
        s_rsp_hs = s_if.rsp_valid && s_if.rsp_ready && (exp_up.size() > 0);
        if (m_cmd_hs)
            checkOutput("m_cmd_payload",
                        {m_if.cmd_addr, m_if.cmd_read, m_if.cmd_wdata, m_if.cmd_wmask}, exp_down[0]);
        if (s_rsp_hs) begin
            checkOutput("s_rsp_payload", {s_if.rsp_rdata, s_if.rsp_err}, slave_reply(exp_up[0]));
            if (s_if.rsp_err) err_seen++;
        end
        @(posedge clk);
        cycle++;
        if (m_cmd_hs) begin
            down_c = exp_down.pop_front();
            slave_q.push_back(down_c);
        end
        if (s_cmd_hs) begin
            exp_down.push_back(tx_q[0]);
            exp_up.push_back(tx_q[0]);
            void'(tx_q.pop_front());
            m_hold = 1'b0;
            n_accepted++;
            last_cmd_cycle = cycle;
        end
        if (m_rsp_hs) begin
            void'(slave_q.pop_front());
            sl_hold = 1'b0;
            rsp_buf_cnt++;
        end
        if (s_rsp_hs) begin
            void'(exp_up.pop_front());
            rsp_buf_cnt--;
            n_rsp++;
            last_rsp_cycle = cycle;
        end
    endtask

    // Step until everything issued has been answered, within a cycle budget.
    task automatic drainAll(input int limit);
        int k = 0;
        while ((tx_q.size() > 0 || exp_up.size() > 0) && k < limit) begin
            applyStimulus();
            k++;
        end
        checkOutput("drain_done", (tx_q.size() == 0) && (exp_up.size() == 0), 1);
    endtask

    // Assert reset between edges, check the cleared state, then release.
    task automatic applyReset(input bit hold_valid);
        @(negedge clk);
        rst_n          = 1'b0;
        s_if.cmd_valid = hold_valid;
        m_if.cmd_ready = 1'b1;
        m_if.rsp_valid = 1'b0;
        s_if.rsp_ready = 1'b1;
        m_hold = 1'b0;
        sl_hold = 1'b0;
        tx_q.delete();
        exp_down.delete();
        exp_up.delete();
        slave_q.delete();
        rsp_buf_cnt = 0;
        #1;
        checkOutput("rst_s_cmd_ready", s_if.cmd_ready, 0);
        checkOutput("rst_m_rsp_ready", m_if.rsp_ready, 0);
        checkOutput("rst_m_cmd_valid", m_if.cmd_valid, 0);
        checkOutput("rst_s_rsp_valid", s_if.rsp_valid, 0);
        checkOutput("rst_idle", idle, 1);
        checkOutput("rst_outstanding", outstanding, 0);
        checkOutput("rst_m_cmd_addr", m_if.cmd_addr, 0);
        checkOutput("rst_s_rsp_rdata", s_if.rsp_rdata, 0);
        repeat (2) @(negedge clk);
        checkOutput("rst_hold_s_cmd_ready", s_if.cmd_ready, 0);
        rst_n          = 1'b1;
        s_if.cmd_valid = 1'b0;
        #1;
        checkOutput("rel_s_cmd_ready", s_if.cmd_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        s_if.cmd_valid = 1'b0;
        s_if.cmd_addr  = '0;
        s_if.cmd_read  = 1'b0;
        s_if.cmd_wdata = '0;
        s_if.cmd_wmask = '0;
        s_if.rsp_ready = 1'b0;
        m_if.cmd_ready = 1'b0;
        m_if.rsp_valid = 1'b0;
        m_if.rsp_rdata = '0;
        m_if.rsp_err   = 1'b0;

        $display("[TB] T1 reset with command valid held high");
        applyReset(1'b1);

        $display("[TB] T2 single read, round-trip latency");
        tx_q.push_back(make_cmd(32'h1000, 1'b1));
        drainAll(50);
        checkOutput("t2_latency", last_rsp_cycle - last_cmd_cycle, 3);

        $display("[TB] T3 outstanding cap");
        slave_rsp_pct = 0;
        n_accepted = 0;
        for (int i = 0; i < 6; i++) tx_q.push_back(make_cmd(32'h100 + 8 * i, 1'b0));
        repeat (12) applyStimulus();
        checkOutput("t3_accepted_at_cap", n_accepted, 4);
        slave_rsp_pct = 100;
        drainAll(100);
        checkOutput("t3_accepted_total", n_accepted, 6);

        $display("[TB] T4 downstream backpressure");
        mcmd_ready_pct = 0;
        n_accepted = 0;
        for (int i = 0; i < 3; i++) tx_q.push_back(make_cmd(8 * i, 1'b0));
        repeat (6) applyStimulus();
        checkOutput("t4_accepted_full", n_accepted, 2);
        mcmd_ready_pct = 100;
        drainAll(100);

        $display("[TB] T5 random stream");
        cmd_valid_pct  = 70;
        mcmd_ready_pct = 60;
        slave_rsp_pct  = 60;
        srsp_ready_pct = 60;
        err_seen = 0;
        n_rsp = 0;
        for (int i = 0; i < 64; i++) begin
            if (i == 0 || $urandom_range(7) == 0)
                tx_q.push_back(make_cmd(32'hBAD0, $urandom_range(1) == 1));
            else
                tx_q.push_back(make_cmd($urandom & 32'hFFF8, $urandom_range(1) == 1));
        end
        drainAll(3000);
        checkOutput("t5_rsp_count", n_rsp, 64);
        checkOutput("t5_err_seen", err_seen > 0, 1);

        $display("[TB] T6 reset mid-operation");
        cmd_valid_pct  = 100;
        mcmd_ready_pct = 100;
        slave_rsp_pct  = 100;
        srsp_ready_pct = 0;
        tx_q.push_back(make_cmd(32'h2000, 1'b1));
        repeat (6) applyStimulus();
        mcmd_ready_pct = 0;
        tx_q.push_back(make_cmd(32'h2008, 1'b0));
        tx_q.push_back(make_cmd(32'h2010, 1'b0));
        repeat (6) applyStimulus();
        applyReset(1'b0);
        mcmd_ready_pct = 100;
        srsp_ready_pct = 100;
        n_rsp = 0;
        tx_q.push_back(make_cmd(32'h3000, 1'b1));
        drainAll(50);
        checkOutput("t6_fresh_rsp", n_rsp, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
